maze_solve_gen: RTL and testbench
=================================

Name: maze_solve_gen

Overview:
- Parametrised successor to the first-generation solver FSM.
- Sits between cmd_proc (mode and start) and navigate (heading and move handshakes).
- Runs wall-following with run-time selectable policy: left-hug, right-hug, alternating, straight-first.
- Counts issued moves; aborts with a fail flag at a move budget; reports done/fail status.

Parameters:
HDG_W, 12, width of dsrd_hdng; one turn = 2^(HDG_W-2), turn-around = 2^(HDG_W-1)
STARTUP_HDG, 0, reset value of dsrd_hdng (HDG_W bits)
MV_CNT_W, 8, width of move counter
MAX_MOVES, 200, move budget; must be < 2^MV_CNT_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_md  in  1  0 = solve mode requested; 1 = abort/idle
pol  in  2  policy: 00 left-hug, 01 right-hug, 10 alternating, 11 straight-first
frnt_opn  in  1  front opening present at cell
lft_opn  in  1  left opening present
rght_opn  in  1  right opening present
mv_cmplt  in  1  navigate finished current heading or move (1-cycle pulse)
sol_cmplt  in  1  target reached
strt_hdng  out  1  1-cycle pulse: navigate to dsrd_hdng
dsrd_hdng  out  HDG_W  desired heading
strt_mv  out  1  1-cycle pulse: start forward move
stp_lft  out  1  navigate stops at left opening
stp_rght  out  1  navigate stops at right opening
solving  out  1  FSM not in IDLE/DONE/FAIL
done  out  1  sticky: solved
fail  out  1  sticky: move budget exhausted
mv_cnt  out  MV_CNT_W  moves issued this run

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; dsrd_hdng = STARTUP_HDG.
  - All pulses, done, fail and mv_cnt = 0.
  - Preference register pref_lft = 1.
- States: IDLE, FWD, DECIDE, WAIT_HDG, DONE, FAIL.
- IDLE, cmd_md==0:
  - Latch pol into pol_q.
  - Clear mv_cnt, done, fail; pref_lft = 1.
  - Assert strt_mv that cycle; mv_cnt becomes 1; go to FWD.
- FWD:
  - sol_cmplt has priority: go to DONE, done = 1.
  - Else mv_cmplt: go to DECIDE.
- DECIDE (one cycle, uses openings sampled that cycle), order of preference:
  - left-hug: L, F, R, around.
  - right-hug: R, F, L, around.
  - alternating: pref side, F, other side, around; pref_lft toggles on every turn-around.
  - straight-first: F, L, R, around.
- DECIDE, straight chosen:
  - No heading change; no strt_hdng.
  - Assert strt_mv in the same cycle; go to FWD.
- DECIDE, turn chosen:
  - Update dsrd_hdng on this clock: left +quarter, right -quarter, around +half. Arithmetic is modulo 2^HDG_W (wraps, no saturation).
  - Assert strt_hdng in the same cycle.
  - Go to WAIT_HDG; dsrd_hdng is already updated when strt_hdng is seen.
- WAIT_HDG, mv_cmplt: assert strt_mv; go to FWD.
- Budget check: every strt_mv increments mv_cnt.
  - If a strt_mv would be issued while mv_cnt == MAX_MOVES, no pulse is issued.
  - Instead go to FAIL and set fail = 1.
- stp_lft / stp_rght (combinational from pol_q, pref_lft):
  - left-hug: 1/0.
  - right-hug: 0/1.
  - alternating: pref_lft / !pref_lft.
  - straight-first: 0/0 (stop at front wall only).
- DONE / FAIL:
  - Hold, with flags sticky.
  - Return to IDLE when cmd_md==1; a new run starts on the next cmd_md==0.
- Abort: cmd_md==1 in FWD, DECIDE or WAIT_HDG:
  - Go to IDLE next clock; no pulses that cycle.
  - dsrd_hdng retained; mv_cnt frozen.
- Simultaneous events:
  - sol_cmplt + mv_cmplt in FWD: DONE wins.
  - Abort beats every other transition.
- Pulse rules: strt_hdng and strt_mv are never asserted in the same cycle. Each is exactly 1 cycle.
- solving = 1 in FWD, DECIDE, WAIT_HDG.

Decomposition:
- Package maze_pkg holds:
  - state_t enum.
  - pol_t enum (POL_LEFT, POL_RIGHT, POL_ALT, POL_STRAIGHT).
  - turn_t enum (T_STRAIGHT, T_LEFT, T_RIGHT, T_AROUND).
- Sub-module maze_turn_sel (combinational): inputs pol_q, pref_lft, frnt/lft/rght_opn; output turn_t. Keeps policy priority separately testable.

Test Plan:
- pol=00, heading 0x000, cmd_md→0: strt_mv one cycle after IDLE exit, mv_cnt=1. mv_cmplt with L=1: dsrd_hdng=0x400 and strt_hdng in the same cycle. Next mv_cmplt: strt_mv, mv_cnt=2.
- pol=01, dsrd_hdng=0x000, R=0, F=0, L=0: turn-around gives dsrd_hdng=0x800. Repeat from 0xC00 with R=1: gives 0x800 (wrap check via 0x000-0x400=0xC00 first).
- pol=11, F=1, L=1: no strt_hdng, strt_mv pulse in DECIDE cycle, dsrd_hdng unchanged, stp_lft=stp_rght=0.
- pol=10, dead end: pref_lft toggles 1→0, so stp_lft=0 and stp_rght=1. Next junction with L=1, R=1: turn right, dsrd_hdng -0x400.
- MAX_MOVES=3: third completion gives fail=1, state FAIL, no 4th strt_mv. cmd_md→1 then 0: fail cleared, mv_cnt=1.
- sol_cmplt and mv_cmplt same cycle in FWD: done=1, no strt_hdng. Abort in WAIT_HDG: IDLE, no strt_mv on following mv_cmplt. Reset mid-run: dsrd_hdng=STARTUP_HDG.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types for the wall-following maze solver: FSM states, policy and turn codes.
package maze_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FWD, S_DECIDE, S_WAIT_HDG, S_DONE, S_FAIL} state_t;
  typedef enum logic [1:0] {POL_LEFT, POL_RIGHT, POL_ALT, POL_STRAIGHT} pol_t;
  typedef enum logic [1:0] {T_STRAIGHT, T_LEFT, T_RIGHT, T_AROUND} turn_t;
endpackage

// File: rtl/maze_turn_sel.sv
// Policy priority: picks the turn at a junction from the openings seen this cycle.
module maze_turn_sel
  import maze_pkg::*;
(
  input  pol_t  i_pol,
  input  logic  i_pref_lft,
  input  logic  i_frnt_opn,
  input  logic  i_lft_opn,
  input  logic  i_rght_opn,
  output turn_t o_turn
);
  // Alternating policy: "preferred" side first, the other side after front.
  logic  w_pref_opn, w_oth_opn;
  turn_t w_pref_t, w_oth_t;

  assign w_pref_opn = i_pref_lft ? i_lft_opn  : i_rght_opn;
  assign w_oth_opn  = i_pref_lft ? i_rght_opn : i_lft_opn;
  assign w_pref_t   = i_pref_lft ? T_LEFT     : T_RIGHT;
  assign w_oth_t    = i_pref_lft ? T_RIGHT    : T_LEFT;

  always_comb begin
    o_turn = T_AROUND;
    case (i_pol)
      POL_LEFT: begin
        if      (i_lft_opn)  o_turn = T_LEFT;
        else if (i_frnt_opn) o_turn = T_STRAIGHT;
        else if (i_rght_opn) o_turn = T_RIGHT;
      end
      POL_RIGHT: begin
        if      (i_rght_opn) o_turn = T_RIGHT;
        else if (i_frnt_opn) o_turn = T_STRAIGHT;
        else if (i_lft_opn)  o_turn = T_LEFT;
      end
      POL_ALT: begin
        if      (w_pref_opn) o_turn = w_pref_t;
        else if (i_frnt_opn) o_turn = T_STRAIGHT;
        else if (w_oth_opn)  o_turn = w_oth_t;
      end
      default: begin
        if      (i_frnt_opn) o_turn = T_STRAIGHT;
        else if (i_lft_opn)  o_turn = T_LEFT;
        else if (i_rght_opn) o_turn = T_RIGHT;
      end
    endcase
  end
endmodule

// File: rtl/maze_solve_gen.sv
// Wall-following maze solver FSM: issues heading/move pulses to navigate under a move budget.
module maze_solve_gen
  import maze_pkg::*;
#(
  parameter int                 HDG_W       = 12,
  parameter logic [HDG_W-1:0]   STARTUP_HDG = '0,
  parameter int                 MV_CNT_W    = 8,
  parameter int                 MAX_MOVES   = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cmd_md,
  input  logic [1:0]          i_pol,
  input  logic                i_frnt_opn,
  input  logic                i_lft_opn,
  input  logic                i_rght_opn,
  input  logic                i_mv_cmplt,
  input  logic                i_sol_cmplt,
  output logic                o_strt_hdng,
  output logic [HDG_W-1:0]    o_dsrd_hdng,
  output logic                o_strt_mv,
  output logic                o_stp_lft,
  output logic                o_stp_rght,
  output logic                o_solving,
  output logic                o_done,
  output logic                o_fail,
  output logic [MV_CNT_W-1:0] o_mv_cnt
);
  localparam logic [HDG_W-1:0]    QTR  = {2'b01, {(HDG_W-2){1'b0}}};
  localparam logic [HDG_W-1:0]    HALF = {1'b1, {(HDG_W-1){1'b0}}};
  localparam logic [MV_CNT_W-1:0] MAXM = MV_CNT_W'(MAX_MOVES);

  state_t              r_state;
  pol_t                r_pol;
  logic                r_pref;
  logic [HDG_W-1:0]    r_hdg;
  logic                r_sh, r_sm, r_done, r_fail;
  logic [MV_CNT_W-1:0] r_cnt;
  turn_t               w_turn;
  logic                w_budget_hit;

  maze_turn_sel u_turn_sel (
    .i_pol      (r_pol),
    .i_pref_lft (r_pref),
    .i_frnt_opn (i_frnt_opn),
    .i_lft_opn  (i_lft_opn),
    .i_rght_opn (i_rght_opn),
    .o_turn     (w_turn)
  );

  assign w_budget_hit = (r_cnt == MAXM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pol   <= POL_LEFT;
      r_pref  <= 1'b1;
      r_hdg   <= STARTUP_HDG;
      r_sh    <= 1'b0;
      r_sm    <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sh <= 1'b0;
      r_sm <= 1'b0;
      case (r_state)
        S_IDLE: if (!i_cmd_md) begin
          r_pol  <= pol_t'(i_pol);
          r_pref <= 1'b1;
          r_done <= 1'b0;
          if (MAX_MOVES == 0) begin
            r_cnt   <= '0;
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end else begin
            r_fail  <= 1'b0;
            r_cnt   <= MV_CNT_W'(1);
            r_sm    <= 1'b1;
            r_state <= S_FWD;
          end
        end
        S_FWD: begin
          if      (i_cmd_md)    r_state <= S_IDLE;
          else if (i_sol_cmplt) begin r_state <= S_DONE; r_done <= 1'b1; end
          else if (i_mv_cmplt)  r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (i_cmd_md) r_state <= S_IDLE;
          else if (w_turn == T_STRAIGHT) begin
            if (w_budget_hit) begin r_fail <= 1'b1; r_state <= S_FAIL; end
            else begin r_sm <= 1'b1; r_cnt <= r_cnt + 1'b1; r_state <= S_FWD; end
          end else begin
            // Heading lands on the same edge as strt_hdng so navigate sees it updated.
            case (w_turn)
              T_LEFT:  r_hdg <= r_hdg + QTR;
              T_RIGHT: r_hdg <= r_hdg - QTR;
              default: begin
                r_hdg <= r_hdg + HALF;
                if (r_pol == POL_ALT) r_pref <= ~r_pref;
              end
            endcase
            r_sh    <= 1'b1;
            r_state <= S_WAIT_HDG;
          end
        end
        S_WAIT_HDG: begin
          if (i_cmd_md) r_state <= S_IDLE;
          else if (i_mv_cmplt) begin
            if (w_budget_hit) begin r_fail <= 1'b1; r_state <= S_FAIL; end
            else begin r_sm <= 1'b1; r_cnt <= r_cnt + 1'b1; r_state <= S_FWD; end
          end
        end
        default: if (i_cmd_md) r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_stp_lft  = 1'b0;
    o_stp_rght = 1'b0;
    case (r_pol)
      POL_LEFT:  o_stp_lft  = 1'b1;
      POL_RIGHT: o_stp_rght = 1'b1;
      POL_ALT:   begin o_stp_lft = r_pref; o_stp_rght = ~r_pref; end
      default:   ;
    endcase
  end

  assign o_strt_hdng = r_sh;
  assign o_strt_mv   = r_sm;
  assign o_dsrd_hdng = r_hdg;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_mv_cnt    = r_cnt;
  assign o_solving   = (r_state == S_FWD) || (r_state == S_DECIDE) || (r_state == S_WAIT_HDG);
endmodule

// File: tb/tb_maze_solve_gen.sv
// Bench for maze_solve_gen: reference model checked every cycle, plus directed and table-driven junctions.
module tb_maze_solve_gen;
  localparam int HW   = 12;
  localparam int MAXM = 8;

  logic clk = 0, rst_n = 0;
  logic cmd_md = 1, f = 0, l = 0, r = 0, mv = 0, sol = 0;
  logic [1:0] pol = 0;
  logic sh, sm, stp_l, stp_r, solving, done, fail;
  logic [HW-1:0] hdg;
  logic [7:0] cnt;

  maze_solve_gen #(.HDG_W(HW), .STARTUP_HDG('0), .MV_CNT_W(8), .MAX_MOVES(MAXM)) dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_md(cmd_md), .i_pol(pol), .i_frnt_opn(f), .i_lft_opn(l),
    .i_rght_opn(r), .i_mv_cmplt(mv), .i_sol_cmplt(sol), .o_strt_hdng(sh), .o_dsrd_hdng(hdg),
    .o_strt_mv(sm), .o_stp_lft(stp_l), .o_stp_rght(stp_r), .o_solving(solving), .o_done(done),
    .o_fail(fail), .o_mv_cnt(cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 forward, 2 decide, 3 wait heading, 4 done, 5 fail.
  int ms, mh, mc, mpol;
  bit md, mf, mpref, msh, msm;

  function automatic void m_reset();
    ms = 0; mh = 0; mc = 0; mpol = 0; md = 0; mf = 0; mpref = 1; msh = 0; msm = 0;
  endfunction

  function automatic void m_move();
    if (mc == MAXM) begin mf = 1; ms = 5; end
    else begin msm = 1; mc++; ms = 1; end
  endfunction

  // Direction codes: 0 front, 1 left, 2 right, 3 around (always available).
  function automatic int m_choose();
    int ord[4];
    bit opn[4];
    opn = '{f, l, r, 1'b1};
    case (mpol)
      0: ord = '{1, 0, 2, 3};
      1: ord = '{2, 0, 1, 3};
      2: ord = mpref ? '{1, 0, 2, 3} : '{2, 0, 1, 3};
      default: ord = '{0, 1, 2, 3};
    endcase
    for (int i = 0; i < 4; i++) if (opn[ord[i]]) return ord[i];
    return 3;
  endfunction

  function automatic void m_step();
    int t;
    msh = 0; msm = 0;
    case (ms)
      0: if (!cmd_md) begin mpol = pol; mc = 0; md = 0; mf = 0; mpref = 1; m_move(); end
      1: if (cmd_md) ms = 0; else if (sol) begin ms = 4; md = 1; end else if (mv) ms = 2;
      2: if (cmd_md) ms = 0;
         else begin
           t = m_choose();
           if (t == 0) m_move();
           else begin
             mh = (mh + (t == 1 ? 1024 : t == 2 ? 3072 : 2048)) % 4096;
             msh = 1; ms = 3;
             if (t == 3 && mpol == 2) mpref = !mpref;
           end
         end
      3: if (cmd_md) ms = 0; else if (mv) m_move();
      default: if (cmd_md) ms = 0;
    endcase
  endfunction

  task automatic cmp_all();
    chk("solving", solving, (ms >= 1 && ms <= 3));
    chk("strt_hdng", sh, msh);
    chk("strt_mv", sm, msm);
    chk("dsrd_hdng", hdg, mh);
    chk("mv_cnt", cnt, mc);
    chk("done", done, md);
    chk("fail", fail, mf);
    chk("stp_lft", stp_l, (mpol == 0) || (mpol == 2 && mpref));
    chk("stp_rght", stp_r, (mpol == 1) || (mpol == 2 && !mpref));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    cmp_all();
  endtask

  task automatic start(input logic [1:0] p);
    cmd_md = 1; tick();
    cmd_md = 0; pol = p; tick();
    chk("start_mv", sm, 1);
    chk("start_cnt", cnt, 1);
  endtask

  // One junction: completion, decide cycle, and the follow-up completion if it was a turn.
  task automatic jn(input logic jf, jl, jr, input int exp_h, input bit turn);
    f = jf; l = jl; r = jr;
    mv = 1; tick();
    mv = 0; tick();
    chk("jn_hdg", hdg, exp_h);
    chk("jn_hdng_pulse", sh, turn);
    chk("jn_mv_pulse", sm, !turn);
    if (turn) begin
      mv = 1; tick();
      chk("jn_post_mv", sm, 1);
      mv = 0;
    end
  endtask

  typedef struct { logic [1:0] pol; logic f, l, r; int turn; } vec_t;
  vec_t vt[16];
  int delta[4] = '{0, 1024, 3072, 2048};

  initial begin
    m_reset();
    #3;
    cmp_all();
    chk("rst_hdg", hdg, 0);
    rst_n = 1;

    // Left-hug: first move, left turn, follow-up move
    cmd_md = 0; pol = 0; tick();
    chk("l_mv", sm, 1); chk("l_cnt", cnt, 1);
    l = 1; mv = 1; tick();
    mv = 0; tick();
    chk("l_hdg", hdg, 'h400); chk("l_sh", sh, 1); chk("l_nomv", sm, 0);
    mv = 1; tick();
    chk("l_mv2", sm, 1); chk("l_cnt2", cnt, 2);
    mv = 0; l = 0;

    // Right-hug: right turn, dead-end turn-around, and wrap through zero
    start(2'd1);
    jn(0, 0, 1, 'h000, 1);
    jn(0, 0, 0, 'h800, 1);
    jn(0, 0, 1, 'h400, 1);
    jn(0, 0, 1, 'h000, 1);
    jn(0, 0, 1, 'hC00, 1);
    jn(0, 0, 1, 'h800, 1);

    // Straight-first: front taken with left also open
    start(2'd3);
    jn(1, 1, 0, 'h800, 0);
    chk("s_stp_l", stp_l, 0); chk("s_stp_r", stp_r, 0);

    // Alternating: dead end flips preference to right
    start(2'd2);
    chk("a_stp_l0", stp_l, 1);
    jn(0, 0, 0, 'h000, 1);
    chk("a_stp_l", stp_l, 0); chk("a_stp_r", stp_r, 1);
    jn(0, 1, 1, 'hC00, 1);

    // Budget exhaustion
    start(2'd3);
    for (int i = 0; i < MAXM - 1; i++) jn(1, 0, 0, 'hC00, 0);
    chk("b_cnt", cnt, MAXM);
    mv = 1; tick();
    mv = 0; tick();
    chk("b_fail", fail, 1); chk("b_nomv", sm, 0); chk("b_solving", solving, 0);
    tick();
    chk("b_sticky", fail, 1);
    start(2'd3);
    chk("b_clear", fail, 0);

    // Solve and completion in the same cycle
    mv = 1; sol = 1; tick();
    chk("d_done", done, 1); chk("d_nosh", sh, 0); chk("d_solving", solving, 0);
    mv = 0; sol = 0; tick();
    chk("d_sticky", done, 1);

    // Abort while waiting for heading
    start(2'd0);
    f = 0; l = 1; r = 0;
    mv = 1; tick();
    mv = 0; tick();
    chk("ab_sh", sh, 1);
    cmd_md = 1; tick();
    chk("ab_idle", solving, 0);
    mv = 1; tick();
    chk("ab_nomv", sm, 0);
    chk("ab_hdg", hdg, 'h000);
    mv = 0;

    // Single-junction table across all policies
    vt[0]  = '{0, 1, 1, 1, 1}; vt[1]  = '{0, 1, 0, 1, 0}; vt[2]  = '{0, 0, 0, 1, 2}; vt[3]  = '{0, 0, 0, 0, 3};
    vt[4]  = '{1, 1, 1, 1, 2}; vt[5]  = '{1, 1, 1, 0, 0}; vt[6]  = '{1, 0, 1, 0, 1}; vt[7]  = '{1, 0, 0, 0, 3};
    vt[8]  = '{2, 1, 1, 1, 1}; vt[9]  = '{2, 1, 0, 1, 0}; vt[10] = '{2, 0, 0, 1, 2}; vt[11] = '{2, 0, 0, 0, 3};
    vt[12] = '{3, 1, 1, 1, 0}; vt[13] = '{3, 0, 1, 1, 1}; vt[14] = '{3, 0, 0, 1, 2}; vt[15] = '{3, 0, 0, 0, 3};
    for (int k = 0; k < 16; k++) begin
      int eh;
      start(vt[k].pol);
      eh = (mh + delta[vt[k].turn]) % 4096;
      jn(vt[k].f, vt[k].l, vt[k].r, eh, vt[k].turn != 0);
    end

    // Reset in the middle of a run
    start(2'd0);
    jn(0, 1, 0, (mh + 1024) % 4096, 1);
    rst_n = 0; #1;
    m_reset();
    cmp_all();
    chk("mr_hdg", hdg, 0);
    #1 rst_n = 1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cmd_md = ($urandom_range(0, 19) == 0);
      pol    = 2'($urandom_range(0, 3));
      f      = 1'($urandom_range(0, 1));
      l      = 1'($urandom_range(0, 1));
      r      = 1'($urandom_range(0, 1));
      mv     = ($urandom_range(0, 2) == 0);
      sol    = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
